ifetch_seq32: RTL and testbench
===============================

Name: ifetch_seq32

Overview:
- Sequential instruction-fetch and PC-update stage for the 32-bit Minisys core.
- Fetches each instruction from instruction memory over a single-outstanding request/valid handshake.
- Holds the instruction stable for decode and execute, and supplies PC_plus_4 and the opcode fields to the executor.
- Consumes the executor's Addr_Result and Zero, the decoder's Read_data_1, and the controller's jump/branch flags to select the next PC. Also counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_ADDR_W, 14, width of the word address to instruction memory.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle fetch request strobe.
- imem_addr  out  IMEM_ADDR_W  word address; equals pc[IMEM_ADDR_W+1:2].
- imem_valid  in  1  instruction-memory data valid.
- imem_rdata  in  32  instruction word; sampled only when imem_valid=1 in WAIT.
- stall  in  1  downstream not ready; hold the current instruction.
- Addr_Result  in  32  branch target from the executor.
- Zero  in  1  executor zero flag.
- Read_data_1  in  32  rs value, used as the jr target.
- Branch  in  1  beq.
- nBranch  in  1  bne.
- Jmp  in  1  j.
- Jal  in  1  jal.
- Jr  in  1  jr.
- Instruction  out  32  registered instruction word to decoder and executor.
- inst_valid  out  1  high while in EXEC.
- pc  out  32  address of the current instruction.
- PC_plus_4  out  32  pc+4, combinational, modulo 2^32; also the jal link value.
- instret  out  32  retired-instruction counter.
- misalign  out  1  sticky flag set on a misaligned jump or branch target.

Behaviour:
Clock/reset:
- Single clock; reset is synchronous and active-high on port reset.
- Reset values: pc=RESET_PC, Instruction=0, inst_valid=0, imem_req=0, instret=0, misalign=0, state=IDLE.
- Reset overrides all other inputs in every state, including mid-WAIT.
- Instruction memory shares the same reset; a response in flight at reset is never sampled, because reset forces IDLE.

FSM:
- IDLE: always exactly one cycle, then REQ.
- REQ: imem_req=1 for one cycle, imem_addr from pc, then WAIT.
- WAIT: imem_req=0.
  - imem_valid=1: Instruction<=imem_rdata, go to EXEC.
  - Otherwise stay in WAIT with no timeout.
  - imem_valid in any state other than WAIT is ignored.
- EXEC: inst_valid=1 and Instruction is stable.
  - stall=1: hold all state; no PC update, no count.
  - stall=0: pc<=next_pc, instret<=instret+1 (wraps at 2^32), go to REQ.

Throughput:
- Minimum 3 cycles per instruction: REQ at t, imem_valid at t+1, EXEC at t+2, next REQ at t+3.

next_pc priority (highest first):
1. Jr: Read_data_1.
2. Jmp or Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
3. Branch&Zero or nBranch&~Zero: Addr_Result.
4. Otherwise: PC_plus_4.

Alignment and wrap:
- If the selected next_pc[1:0]!=0, load next_pc with bits [1:0] forced to 00 and set misalign.
- misalign is cleared only by reset.
- Sequential wrap: pc=32'hFFFF_FFFC gives next pc 32'h0000_0000, with no flag.

Other rules:
- Control inputs are sampled only in EXEC with stall=0 and are don't-care elsewhere.
- Instruction changes only on the WAIT-to-EXEC transition.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding: IDLE, REQ, WAIT, EXEC;
  - RESET_PC default;
  - opcode constants: J=6'b000010, JAL=6'b000011.
- One sub-module is natural: npc_sel, a combinational next-PC priority mux that also outputs the misalign flag. The FSM, pc, instruction and counter registers stay in the top.

Test Plan:
1. Reset then sequential fetch: memory returns 32'h2001_0005 one cycle after each request.
   -> imem_addr 0,1,2; pc 0,4,8; instret 3 after 9 cycles; inst_valid high one cycle in three.
2. beq taken: Branch=1, Zero=1, Addr_Result=32'h0000_0040.
   -> next pc=0x40. Same stimulus with Zero=0 -> pc=PC_plus_4.
3. Priority conflict: Jr=1, Jmp=1, Branch=1, Zero=1, Read_data_1=32'h0000_0100.
   -> pc=0x100. Then Read_data_1=32'h0000_0102 -> pc=0x100, misalign=1 and stays set.
4. jal at pc=32'h1000_0010, Instruction=32'h0C00_0020.
   -> PC_plus_4=32'h1000_0014 during EXEC; next pc=32'h1000_0080.
5. Stall and slow memory: imem_valid delayed 5 cycles, then stall held 4 cycles in EXEC.
   -> imem_req pulses once; Instruction, pc and instret constant throughout; advances on the first stall=0 cycle.
6. Reset asserted mid-WAIT, with imem_valid arriving in the same cycle.
   -> next state IDLE, pc=RESET_PC, Instruction=0, instret=0. Separately, pc=32'hFFFF_FFFC sequential -> pc=0, misalign=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the Minisys fetch stage.
//   fsm_state_t  : fetch sequencer states
//   CPU_RESET_PC : default reset PC
//   OP_J, OP_JAL : jump opcodes (Instruction[31:26])
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    EXEC = 2'd3
  } fsm_state_t;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

endpackage

// File: rtl/ifetch_seq32_npc_sel.sv
// Next-PC priority mux: jr > j/jal > taken branch > sequential.
// Targets with nonzero low bits are word-aligned and flagged.
//   pc_plus_4, instr_index, addr_result, zero, read_data_1,
//   branch, nbranch, jmp, jal, jr : selection inputs
//   next_pc  : aligned next PC
//   misalign : selected target had nonzero bits [1:0]
module npc_sel (
  input  logic [31:0] pc_plus_4,
  input  logic [25:0] instr_index,
  input  logic [31:0] addr_result,
  input  logic        zero,
  input  logic [31:0] read_data_1,
  input  logic        branch,
  input  logic        nbranch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jr,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

  always_comb begin
    target = pc_plus_4;
    if (jr)
      target = read_data_1;
    else if (jmp || jal)
      target = {pc_plus_4[31:28], instr_index, 2'b00};
    else if ((branch && zero) || (nbranch && !zero))
      target = addr_result;
    misalign = |target[1:0];
    next_pc  = {target[31:2], 2'b00};
  end

endmodule

// File: rtl/ifetch_seq32.sv
// Sequential instruction fetch / PC update stage.
// One outstanding fetch: IDLE -> REQ -> WAIT (until imem_valid) -> EXEC
// (until stall drops) -> REQ. PC and retire count advance on leaving EXEC.
//   clock, reset            : clock, synchronous active-high reset
//   imem_req/addr/valid/rdata : instruction memory handshake
//   stall                   : hold the current instruction in EXEC
//   Addr_Result, Zero, Read_data_1, Branch, nBranch, Jmp, Jal, Jr : next-PC inputs
//   Instruction, inst_valid, pc, PC_plus_4 : current instruction to decode/execute
//   instret                 : retired-instruction counter
//   misalign                : sticky misaligned-target flag
module ifetch_seq32
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = CPU_RESET_PC,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_valid,
  input  logic [31:0]            imem_rdata,
  input  logic                   stall,
  input  logic [31:0]            Addr_Result,
  input  logic                   Zero,
  input  logic [31:0]            Read_data_1,
  input  logic                   Branch,
  input  logic                   nBranch,
  input  logic                   Jmp,
  input  logic                   Jal,
  input  logic                   Jr,
  output logic [31:0]            Instruction,
  output logic                   inst_valid,
  output logic [31:0]            pc,
  output logic [31:0]            PC_plus_4,
  output logic [31:0]            instret,
  output logic                   misalign
);

  fsm_state_t  state, state_nxt;
  logic [31:0] next_pc;
  logic        next_mis;
  logic        retire;

  assign PC_plus_4 = pc + 32'd4;
  assign imem_addr = pc[IMEM_ADDR_W+1:2];
  assign retire    = (state == EXEC) && !stall;

  npc_sel u_npc_sel (
    .pc_plus_4   (PC_plus_4),
    .instr_index (Instruction[25:0]),
    .addr_result (Addr_Result),
    .zero        (Zero),
    .read_data_1 (Read_data_1),
    .branch      (Branch),
    .nbranch     (nBranch),
    .jmp         (Jmp),
    .jal         (Jal),
    .jr          (Jr),
    .next_pc     (next_pc),
    .misalign    (next_mis)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      Instruction <= '0;
      instret     <= '0;
      misalign    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && imem_valid)
        Instruction <= imem_rdata;
      if (retire) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
        if (next_mis)
          misalign <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (imem_valid) state_nxt = EXEC;
      EXEC: begin
        inst_valid = 1'b1;
        if (!stall) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifetch_seq32.sv
module tb_ifetch_seq32;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] Addr_Result, Read_data_1;
  logic        Zero, Branch, nBranch, Jmp, Jal, Jr;
  logic [31:0] Instruction, pc, PC_plus_4, instret;
  logic        inst_valid, misalign;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int iv_cnt = 0;

  // behavioural reference state
  logic [31:0] m_pc, m_cnt;
  logic        m_mis;

  ifetch_seq32 #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(14)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall),
    .Addr_Result(Addr_Result), .Zero(Zero), .Read_data_1(Read_data_1),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
    .Instruction(Instruction), .inst_valid(inst_valid),
    .pc(pc), .PC_plus_4(PC_plus_4), .instret(instret), .misalign(misalign)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (inst_valid) iv_cnt <= iv_cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // next PC from the architectural rules, using plain arithmetic
  function automatic logic [32:0] ref_npc(input logic [31:0] cur, instr, addr, rd1,
                                          input logic z, br, nbr, jmp, jal, jr);
    logic [31:0] t;
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jr) t = rd1;
    else if (jmp || jal) t = (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    else if ((br && z) || (nbr && !z)) t = addr;
    else t = seq;
    return {(t % 4) != 0, t - (t % 4)};
  endfunction

  task automatic junk_ctrl();
    Addr_Result = $urandom; Read_data_1 = $urandom;
    {Zero, Branch, nBranch, Jmp, Jal, Jr} = 6'($urandom);
  endtask

  // one full instruction: request, memory latency, stall, retire with controls
  task automatic fetch(input int dly, input int nstall, input logic [31:0] word,
                       input logic [31:0] addr, rd1,
                       input logic z, br, nbr, jmp, jal, jr);
    int w;
    logic [32:0] r;
    w = 0;
    while (imem_req !== 1'b1 && w < 20) begin step(); w++; end
    n_total++;
    if (imem_req !== 1'b1) $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1", imem_req, w);
    else n_pass++;
    n_total++;
    if (imem_addr !== m_pc[15:2]) $display("FAIL imem_addr: got %h required %h", imem_addr, m_pc[15:2]);
    else n_pass++;
    junk_ctrl();
    step();
    for (int i = 0; i < dly; i++) begin
      n_total++;
      if ({imem_req, inst_valid} !== 2'b00) $display("FAIL wait_outputs: req/iv=%b required 00", {imem_req, inst_valid});
      else n_pass++;
      step();
    end
    imem_valid = 1'b1; imem_rdata = word;
    step();
    imem_valid = 1'b0; imem_rdata = $urandom;
    n_total++;
    if ({inst_valid, Instruction, pc, PC_plus_4, instret, misalign} !== {1'b1, word, m_pc, m_pc + 32'd4, m_cnt, m_mis})
      $display("FAIL exec_entry: iv=%b ins=%h pc=%h p4=%h cnt=%0d mis=%b required iv=1 ins=%h pc=%h p4=%h cnt=%0d mis=%b",
               inst_valid, Instruction, pc, PC_plus_4, instret, misalign, word, m_pc, m_pc + 32'd4, m_cnt, m_mis);
    else n_pass++;
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1; junk_ctrl();
      imem_valid = 1'b1; imem_rdata = $urandom;  // must be ignored outside WAIT
      step();
      n_total++;
      if ({inst_valid, imem_req, Instruction, pc, instret} !== {1'b1, 1'b0, word, m_pc, m_cnt})
        $display("FAIL stall_hold: iv=%b req=%b ins=%h pc=%h cnt=%0d required iv=1 req=0 ins=%h pc=%h cnt=%0d",
                 inst_valid, imem_req, Instruction, pc, instret, word, m_pc, m_cnt);
      else n_pass++;
    end
    imem_valid = 1'b0;
    stall = 1'b0;
    Addr_Result = addr; Read_data_1 = rd1;
    Zero = z; Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jr = jr;
    r = ref_npc(m_pc, word, addr, rd1, z, br, nbr, jmp, jal, jr);
    step();
    junk_ctrl();
    m_pc = r[31:0]; m_cnt = m_cnt + 1; m_mis = m_mis | r[32];
    n_total++;
    if ({imem_req, inst_valid, pc, instret, misalign} !== {1'b1, 1'b0, m_pc, m_cnt, m_mis})
      $display("FAIL retire: req=%b iv=%b pc=%h cnt=%0d mis=%b required req=1 iv=0 pc=%h cnt=%0d mis=%b",
               imem_req, inst_valid, pc, instret, misalign, m_pc, m_cnt, m_mis);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); step();
    imem_valid = 1'b0;
    n_total++;
    if ({imem_req, inst_valid, pc, Instruction, instret, misalign} !== {2'b00, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_state: req=%b iv=%b pc=%h ins=%h cnt=%0d mis=%b required all zero",
               imem_req, inst_valid, pc, Instruction, instret, misalign);
    else n_pass++;
    reset = 1'b0;
    m_pc = 32'h0; m_cnt = 0; m_mis = 1'b0;
  endtask

  task automatic test_seq();
    int t0, v0, w;
    w = 0;
    while (imem_req !== 1'b1 && w < 20) begin step(); w++; end
    t0 = cyc; v0 = iv_cnt;
    for (int i = 0; i < 3; i++) fetch(0, 0, 32'h2001_0005, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (cyc - t0 != 9 || iv_cnt - v0 != 3 || instret !== 32'd3 || pc !== 32'hC)
      $display("FAIL seq_throughput: cycles=%0d iv_cycles=%0d instret=%0d pc=%h required 9 3 3 0000000c",
               cyc - t0, iv_cnt - v0, instret, pc);
    else n_pass++;
  endtask

  task automatic test_branch();
    fetch(0, 0, 32'h1000_0003, 32'h0000_0040, 0, 1, 1, 0, 0, 0, 0);   // beq taken -> 0x40
    fetch(0, 0, 32'h1000_0003, 32'h0000_0080, 0, 0, 1, 0, 0, 0, 0);   // beq not taken -> 0x44
    fetch(1, 0, 32'h1400_0003, 32'h0000_0200, 0, 0, 0, 1, 0, 0, 0);   // bne taken -> 0x200
  endtask

  task automatic test_priority();
    fetch(0, 0, 32'h0800_0555, 32'h40, 32'h0000_0100, 1, 1, 0, 1, 0, 1);
    fetch(0, 0, 32'h0800_0555, 32'h40, 32'h0000_0102, 1, 1, 0, 1, 0, 1);
    fetch(0, 0, 32'h2001_0005, 0, 0, 0, 0, 0, 0, 0, 0);               // misalign stays set
  endtask

  task automatic test_jal();
    fetch(0, 0, 32'h0, 0, 32'h1000_0010, 0, 0, 0, 0, 0, 1);
    fetch(0, 0, 32'h0C00_0020, 0, 0, 0, 0, 0, 0, 1, 0);                // -> 0x1000_0080
    n_total++;
    if (pc !== 32'h1000_0080) $display("FAIL jal_target: pc=%h required 10000080", pc);
    else n_pass++;
  endtask

  task automatic test_stall_slow();
    fetch(5, 4, 32'h2002_0007, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    for (int i = 0; i < 25; i++) begin
      a = $urandom; d = $urandom;
      if ($urandom_range(3) != 0) begin a[1:0] = 2'b00; d[1:0] = 2'b00; end
      fetch($urandom_range(3), $urandom_range(2), $urandom, a, d,
            1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(5) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0));
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    w = 0;
    while (imem_req !== 1'b1 && w < 20) begin step(); w++; end
    step(); step();                      // in WAIT
    reset = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    reset = 1'b0; imem_valid = 1'b0;
    n_total++;
    if ({imem_req, inst_valid, pc, Instruction, instret, misalign} !== {2'b00, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_mid_wait: req=%b iv=%b pc=%h ins=%h cnt=%0d mis=%b required all zero",
               imem_req, inst_valid, pc, Instruction, instret, misalign);
    else n_pass++;
    step();
    n_total++;
    if (imem_req !== 1'b1) $display("FAIL idle_one_cycle: imem_req=%b required 1", imem_req);
    else n_pass++;
    m_pc = 32'h0; m_cnt = 0; m_mis = 1'b0;
  endtask

  task automatic test_wrap();
    fetch(0, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1);
    fetch(0, 0, 32'h2001_0005, 0, 0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if ({pc, misalign} !== {32'h0, 1'b0}) $display("FAIL pc_wrap: pc=%h mis=%b required 00000000 0", pc, misalign);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
    Addr_Result = '0; Read_data_1 = '0;
    {Zero, Branch, nBranch, Jmp, Jal, Jr} = '0;
    test_reset();
    test_seq();
    test_branch();
    test_priority();
    test_jal();
    test_stall_slow();
    test_random();
    test_priority();
    test_reset_mid_wait();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
